// File: rtl/fetch_issue_queue_if.sv
// Fetch/decode side bundle of the fetch issue queue: enqueue group, dequeue request,
// presented lanes and occupancy status.
interface fetch_issue_queue_if #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DN_W  = $clog2(ISSUE_W + 1);

  logic                       enable;
  logic                       flush;
  logic [ISSUE_W-1:0]         in_valid;
  logic [ISSUE_W*INSTR_W-1:0] in_instr;
  logic [ISSUE_W*PC_W-1:0]    in_pc;
  logic                       in_ready;
  logic [ISSUE_W-1:0]         out_valid;
  logic [ISSUE_W*INSTR_W-1:0] out_instr;
  logic [ISSUE_W*PC_W-1:0]    out_pc;
  logic [DN_W-1:0]            deq_num;
  logic [CNT_W-1:0]           count;
  logic                       empty;
  logic                       full;

  modport master (
    output enable, flush, in_valid, in_instr, in_pc, deq_num,
    input  in_ready, out_valid, out_instr, out_pc, count, empty, full
  );

  modport slave (
    input  enable, flush, in_valid, in_instr, in_pc, deq_num,
    output in_ready, out_valid, out_instr, out_pc, count, empty, full
  );
endinterface

// File: rtl/fetch_issue_queue.sv
// Multi-lane circular instruction buffer between fetch and decode: up to ISSUE_W
// {instr, pc} entries in and out per cycle, with stall (enable) and flush.
module fetch_issue_queue #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  fetch_issue_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_ready;
  logic               w_enq_fire;
  logic               w_run;
  logic [CNT_W-1:0]   w_n_valid;
  logic [CNT_W-1:0]   w_n_enq;
  logic [CNT_W-1:0]   w_n_deq;
  logic [ISSUE_W-1:0] w_lane_we;

  // Space check uses the pre-dequeue count so in_ready never depends on deq_num.
  assign w_ready    = (CNT_W'(DEPTH) - r_count) >= CNT_W'(ISSUE_W);
  assign w_enq_fire = bus.enable & w_ready & ~bus.flush;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_n_valid = '0;
    w_run     = 1'b1;
    for (int i = 0; i < ISSUE_W; i++) begin
      w_run = w_run & bus.in_valid[i];
      if (w_run) w_n_valid = w_n_valid + CNT_W'(1);
    end
  end

  // Only the leading contiguous valid lanes are taken; a gap ends the group.
  always_comb begin
    w_n_enq   = w_enq_fire ? w_n_valid : '0;
    w_lane_we = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      w_lane_we[i] = w_enq_fire && (CNT_W'(i) < w_n_valid);
    end
  end

  always_comb begin
    w_n_deq = CNT_W'(bus.deq_num);
    if (w_n_deq > r_count)         w_n_deq = r_count;
    if (w_n_deq > CNT_W'(ISSUE_W)) w_n_deq = CNT_W'(ISSUE_W);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.enable) begin
      if (bus.flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PTR_W'(w_n_deq);
        r_tail  <= r_tail + PTR_W'(w_n_enq);
        r_count <= r_count + w_n_enq - w_n_deq;
      end
    end
  end

  // NOTE: the storage array is reset as well, so the don't-care data on
  // invalid read lanes is a defined zero rather than X after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_instr[e] <= '0;
        r_pc[e]    <= '0;
      end
    end else begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (w_lane_we[i]) begin
          r_instr[r_tail + PTR_W'(i)] <= bus.in_instr[i*INSTR_W +: INSTR_W];
          r_pc[r_tail + PTR_W'(i)]    <= bus.in_pc[i*PC_W +: PC_W];
        end
      end
    end
  end

  // Read lanes wrap naturally because DEPTH is a power of two.
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd_lane
    assign bus.out_instr[g*INSTR_W +: INSTR_W] = r_instr[r_head + PTR_W'(g)];
    assign bus.out_pc[g*PC_W +: PC_W]          = r_pc[r_head + PTR_W'(g)];
    assign bus.out_valid[g]                    = r_count > CNT_W'(g);
  end

  assign bus.in_ready = w_ready;
  assign bus.count    = r_count;
  assign bus.empty    = (r_count == '0);
  assign bus.full     = (r_count == CNT_W'(DEPTH));
endmodule

// File: tb/tb_fetch_issue_queue.sv
// Scoreboard bench for fetch_issue_queue (ISSUE_W=2, DEPTH=8): accepted lanes are
// pushed to a queue, dequeued lanes popped, and presented lanes compared each cycle.
module tb_fetch_issue_queue;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 8;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 8;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  entry_t sb[$];
  int errors = 0;
  int checks = 0;

  fetch_issue_queue_if #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();

  fetch_issue_queue #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Fetch must present thermometer-coded valids from lane 0.
  always @(posedge clk) begin
    if (rst && bus.enable) begin
      assert ((bus.in_valid & (bus.in_valid + 2'b01)) == 2'b00)
        else $error("non-thermometer in_valid %b", bus.in_valid);
    end
  end

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [PC_W-1:0] pc);
    return {8'hA5, pc, ~pc, 8'h3C};
  endfunction

  // Drive one cycle, advance the scoreboard model, then compare after the edge.
  task automatic drive_cycle(input logic en, input logic fl, input logic [1:0] v,
                             input logic [7:0] pc0, input logic [7:0] pc1, input int dq);
    int size;
    int nenq;
    int ndeq;
    bit acc;
    logic [3:0] exp_cnt;
    logic exp_v;
    entry_t e;
    size = sb.size();
    acc  = en && !fl && ((DEPTH - size) >= ISSUE_W);
    nenq = v[0] ? (v[1] ? 2 : 1) : 0;
    ndeq = dq;
    if (ndeq > size)    ndeq = size;
    if (ndeq > ISSUE_W) ndeq = ISSUE_W;
    bus.enable   = en;
    bus.flush    = fl;
    bus.in_valid = v;
    bus.in_pc    = {pc1, pc0};
    bus.in_instr = {mk_instr(pc1), mk_instr(pc0)};
    bus.deq_num  = 2'(dq);
    if (en) begin
      if (fl) sb.delete();
      else begin
        repeat (ndeq) void'(sb.pop_front());
        if (acc && nenq > 0) begin e.pc = pc0; e.instr = mk_instr(pc0); sb.push_back(e); end
        if (acc && nenq > 1) begin e.pc = pc1; e.instr = mk_instr(pc1); sb.push_back(e); end
      end
    end
    @(posedge clk);
    #1;
    exp_cnt = 4'(sb.size());
    checks++;
    if (bus.count !== exp_cnt) begin
      errors++;
      $display("FAIL sb_count: got %0d expected %0d", bus.count, exp_cnt);
    end
    checks++;
    if (bus.in_ready !== ((DEPTH - sb.size()) >= ISSUE_W)) begin
      errors++;
      $display("FAIL sb_in_ready: got %b with %0d queued", bus.in_ready, sb.size());
    end
    checks++;
    if (bus.empty !== (sb.size() == 0) || bus.full !== (sb.size() == DEPTH)) begin
      errors++;
      $display("FAIL sb_flags: empty=%b full=%b with %0d queued", bus.empty, bus.full, sb.size());
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      exp_v = (i < sb.size());
      checks++;
      if (bus.out_valid[i] !== exp_v) begin
        errors++;
        $display("FAIL sb_valid lane%0d: got %b expected %b", i, bus.out_valid[i], exp_v);
      end else if (exp_v) begin
        checks++;
        if (bus.out_pc[i*PC_W +: PC_W] !== sb[i].pc ||
            bus.out_instr[i*INSTR_W +: INSTR_W] !== sb[i].instr) begin
          errors++;
          $display("FAIL sb_lane%0d: got pc=%h instr=%h expected pc=%h instr=%h", i,
                   bus.out_pc[i*PC_W +: PC_W], bus.out_instr[i*INSTR_W +: INSTR_W],
                   sb[i].pc, sb[i].instr);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.flush = 1'b0; bus.in_valid = '0;
    bus.in_instr = '0; bus.in_pc = '0; bus.deq_num = '0;
    rst = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 2'b00 || bus.out_instr !== '0 || bus.out_pc !== '0) begin
      errors++;
      $display("FAIL reset_lanes: valid=%b instr=%h pc=%h expected all zero",
               bus.out_valid, bus.out_instr, bus.out_pc);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL reset_status: ready=%b empty=%b full=%b count=%0d expected 1 1 0 0",
               bus.in_ready, bus.empty, bus.full, bus.count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b0, 2'b11, 8'(2*k), 8'(2*k+1), 0);
      checks++;
      if (bus.count !== 4'(2*(k+1))) begin
        errors++;
        $display("FAIL fill_count: got %0d expected %0d", bus.count, 2*(k+1));
      end
    end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.full !== 1'b1 || bus.out_pc !== 16'h0100) begin
      errors++;
      $display("FAIL fill_full: ready=%b full=%b pc=%h expected 0 1 0100",
               bus.in_ready, bus.full, bus.out_pc);
    end
    drive_cycle(1'b1, 1'b0, 2'b11, 8'h08, 8'h09, 0);
    checks++;
    if (bus.count !== 4'd8) begin
      errors++;
      $display("FAIL fill_drop: got count %0d expected 8", bus.count);
    end
  endtask

  task automatic test_steady();
    drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 3);
    drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 2);
    drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 2);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 1'b0, 2'b11, 8'(8'h10 + 2*k), 8'(8'h11 + 2*k), 2);
      checks++;
      if (bus.count !== 4'd2 || bus.out_pc !== {8'(8'h11 + 2*k), 8'(8'h10 + 2*k)}) begin
        errors++;
        $display("FAIL steady_%0d: count=%0d pc=%h expected 2 %h%h", k, bus.count,
                 bus.out_pc, 8'(8'h11 + 2*k), 8'(8'h10 + 2*k));
      end
    end
  endtask

  task automatic test_partial();
    drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 2);
    drive_cycle(1'b1, 1'b0, 2'b01, 8'h09, 8'hEE, 0);
    checks++;
    if (bus.count !== 4'd1 || bus.out_valid !== 2'b01 || bus.out_pc[7:0] !== 8'h09) begin
      errors++;
      $display("FAIL partial_one: count=%0d valid=%b pc=%h expected 1 01 09",
               bus.count, bus.out_valid, bus.out_pc);
    end
    drive_cycle(1'b1, 1'b0, 2'b11, 8'h0A, 8'h0B, 0);
    checks++;
    if (bus.count !== 4'd3 || bus.out_pc !== 16'h0A09) begin
      errors++;
      $display("FAIL partial_two: count=%0d pc=%h expected 3 0a09", bus.count, bus.out_pc);
    end
    drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1);
    checks++;
    if (bus.count !== 4'd2 || bus.out_pc !== 16'h0B0A) begin
      errors++;
      $display("FAIL partial_deq: count=%0d pc=%h expected 2 0b0a", bus.count, bus.out_pc);
    end
  endtask

  task automatic test_clamp();
    drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 1);
    drive_cycle(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 2);
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL clamp: count=%0d empty=%b valid=%b expected 0 1 00",
               bus.count, bus.empty, bus.out_valid);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 1'b0, 2'b11, 8'h20, 8'h21, 0);
    drive_cycle(1'b1, 1'b0, 2'b11, 8'h22, 8'h23, 0);
    drive_cycle(1'b1, 1'b0, 2'b01, 8'h24, 8'h00, 0);
    drive_cycle(1'b1, 1'b1, 2'b11, 8'h30, 8'h31, 2);
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d empty=%b expected 0 1", bus.count, bus.empty);
    end
    drive_cycle(1'b1, 1'b0, 2'b11, 8'h40, 8'h41, 0);
    checks++;
    if (bus.out_pc !== 16'h4140 || bus.out_valid !== 2'b11) begin
      errors++;
      $display("FAIL flush_refill: pc=%h valid=%b expected 4140 11", bus.out_pc, bus.out_valid);
    end
  endtask

  task automatic test_stall_and_reset();
    drive_cycle(1'b1, 1'b0, 2'b01, 8'h42, 8'h00, 0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 1'b0, 2'b11, 8'h50, 8'h51, 2);
      checks++;
      if (bus.count !== 4'd3 || bus.out_pc !== 16'h4140) begin
        errors++;
        $display("FAIL stall_%0d: count=%0d pc=%h expected 3 4140", k, bus.count, bus.out_pc);
      end
    end
    bus.enable = 1'b1; bus.in_valid = 2'b00; bus.deq_num = '0;
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (bus.out_valid !== 2'b00 || bus.count !== 4'd0 || bus.in_ready !== 1'b1 ||
        bus.out_pc !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b count=%0d ready=%b pc=%h expected 00 0 1 0000",
               bus.out_valid, bus.count, bus.in_ready, bus.out_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    drive_cycle(1'b1, 1'b0, 2'b11, 8'h60, 8'h61, 0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_steady();
    test_partial();
    test_clamp();
    test_flush();
    test_stall_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
